// File: rtl/opl3_mem_pkg.sv
// Shared types and sizing for the memory bank write arbiter.
// Holds the clear FSM encoding and the host write bundle.
package opl3_mem_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int DEPTH      = 18;
   localparam int NUM_BANKS  = 2;
   localparam int BANK_WIDTH =
      (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int ADDR_WIDTH = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } clr_state_e;

   typedef struct packed {
      logic [BANK_WIDTH-1:0] bank;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } host_wr_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
// Head entry is visible on dout_o whenever empty_o is low.
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_q];

   // Pointer and occupancy next state; pointers wrap on power-of-2 depth
   always_comb begin
      wr_d  = push_ok ? wr_q + AW'(1) : wr_q;
      rd_d  = pop_ok ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + (AW+1)'(push_ok)
                    - (AW+1)'(pop_ok);
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage array, written on accepted push
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_q] <= din_i;
      end
   end

endmodule

// File: rtl/mem_bank_write_arbiter.sv
// Write-port owner for a multi-bank clearable memory.
// Pipe writes beat host FIFO writes; clears lock both out.
module mem_bank_write_arbiter
   import opl3_mem_pkg::*;
#(
   parameter int HOST_FIFO_DEPTH = 4,
   parameter int CLEAR_TIMEOUT   = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pipe_we,
   input  logic [BANK_WIDTH-1:0] pipe_bank,
   input  logic [ADDR_WIDTH-1:0] pipe_addr,
   input  logic [DATA_WIDTH-1:0] pipe_data,
   input  logic                  host_valid,
   output logic                  host_ready,
   input  logic [BANK_WIDTH-1:0] host_bank,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_data,
   input  logic                  clear_req,
   output logic                  mem_wea,
   output logic [BANK_WIDTH-1:0] mem_banka,
   output logic [ADDR_WIDTH-1:0] mem_addra,
   output logic [DATA_WIDTH-1:0] mem_dia,
   output logic                  mem_reset_mem,
   input  logic                  mem_reset_done,
   output logic                  clear_busy,
   output logic                  clear_done,
   output logic                  pipe_drop,
   output logic                  clear_timeout_err
);

   localparam int CW = $clog2(CLEAR_TIMEOUT + 1);

   clr_state_e            state_q, state_d;
   logic                  pend_q, pend_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  err_q, err_d;

   logic                  wea_q, wea_d;
   logic [BANK_WIDTH-1:0] bank_q, bank_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  rmem_q, rmem_d;
   logic                  cdone_q, cdone_d;
   logic                  drop_q, drop_d;

   host_wr_t              fifo_din, fifo_dout;
   logic                  fifo_push, fifo_pop;
   logic                  fifo_full, fifo_empty;

   assign fifo_din.bank = host_bank;
   assign fifo_din.addr = host_addr;
   assign fifo_din.data = host_data;
   assign fifo_push     = host_valid && host_ready;

   sync_fifo_fwft #(
      .WIDTH ($bits(host_wr_t)),
      .DEPTH (HOST_FIFO_DEPTH)
   ) u_host_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (fifo_push),
      .din_i   (fifo_din),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Clear FSM state, pending flag, wait counter, sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Clear sequencing: issue, wait for done or timeout, re-issue if pending
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      cnt_d   = '0;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (clear_req) state_d = ISSUE;
         end
         ISSUE: begin
            pend_d  = pend_q || clear_req;
            state_d = WAIT;
         end
         WAIT: begin
            pend_d = pend_q || clear_req;
            if (mem_reset_done) begin
               state_d = pend_d ? ISSUE : IDLE;
               pend_d  = 1'b0;
            end else if (cnt_q == CW'(CLEAR_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               pend_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Write-port selection and status pulses for the next cycle
   always_comb begin
      wea_d    = 1'b0;
      bank_d   = bank_q;
      addr_d   = addr_q;
      data_d   = data_q;
      fifo_pop = 1'b0;
      rmem_d   = (state_q == ISSUE);
      cdone_d  = (state_q == WAIT) && mem_reset_done;
      drop_d   = pipe_we && (state_q != IDLE);
      if (state_q == IDLE) begin
         if (pipe_we) begin
            wea_d  = 1'b1;
            bank_d = pipe_bank;
            addr_d = pipe_addr;
            data_d = pipe_data;
         end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            wea_d    = 1'b1;
            bank_d   = fifo_dout.bank;
            addr_d   = fifo_dout.addr;
            data_d   = fifo_dout.data;
         end
      end
   end

   // Registered memory port and status pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         wea_q   <= 1'b0;
         bank_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         rmem_q  <= 1'b0;
         cdone_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         wea_q   <= wea_d;
         bank_q  <= bank_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rmem_q  <= rmem_d;
         cdone_q <= cdone_d;
         drop_q  <= drop_d;
      end
   end

   // Outputs are forced low for the whole reset cycle
   assign host_ready        = !fifo_full && !reset;
   assign mem_wea           = wea_q && !reset;
   assign mem_banka         = reset ? '0 : bank_q;
   assign mem_addra         = reset ? '0 : addr_q;
   assign mem_dia           = reset ? '0 : data_q;
   assign mem_reset_mem     = rmem_q && !reset;
   assign clear_done        = cdone_q && !reset;
   assign pipe_drop         = drop_q && !reset;
   assign clear_timeout_err = err_q && !reset;
   assign clear_busy        =
      ((state_q != IDLE) || pend_q) && !reset;

endmodule

// File: tb/tb_mem_bank_write_arbiter.sv
// Bench for mem_bank_write_arbiter: directed scenarios and a
// random phase, all checked against a transaction-level model.
module tb_mem_bank_write_arbiter;
   import opl3_mem_pkg::*;

   localparam int FD  = 4;
   localparam int TMO = 1024;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  pipe_we;
   logic [BANK_WIDTH-1:0] pipe_bank;
   logic [ADDR_WIDTH-1:0] pipe_addr;
   logic [DATA_WIDTH-1:0] pipe_data;
   logic                  host_valid;
   logic                  host_ready;
   logic [BANK_WIDTH-1:0] host_bank;
   logic [ADDR_WIDTH-1:0] host_addr;
   logic [DATA_WIDTH-1:0] host_data;
   logic                  clear_req;
   logic                  mem_wea;
   logic [BANK_WIDTH-1:0] mem_banka;
   logic [ADDR_WIDTH-1:0] mem_addra;
   logic [DATA_WIDTH-1:0] mem_dia;
   logic                  mem_reset_mem;
   logic                  mem_reset_done;
   logic                  clear_busy;
   logic                  clear_done;
   logic                  pipe_drop;
   logic                  clear_timeout_err;

   always #5 clk = ~clk;

   mem_bank_write_arbiter #(
      .HOST_FIFO_DEPTH (FD),
      .CLEAR_TIMEOUT   (TMO)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .pipe_we           (pipe_we),
      .pipe_bank         (pipe_bank),
      .pipe_addr         (pipe_addr),
      .pipe_data         (pipe_data),
      .host_valid        (host_valid),
      .host_ready        (host_ready),
      .host_bank         (host_bank),
      .host_addr         (host_addr),
      .host_data         (host_data),
      .clear_req         (clear_req),
      .mem_wea           (mem_wea),
      .mem_banka         (mem_banka),
      .mem_addra         (mem_addra),
      .mem_dia           (mem_dia),
      .mem_reset_mem     (mem_reset_mem),
      .mem_reset_done    (mem_reset_done),
      .clear_busy        (clear_busy),
      .clear_done        (clear_done),
      .pipe_drop         (pipe_drop),
      .clear_timeout_err (clear_timeout_err)
   );

   int checks = 0;
   int errors = 0;

   // reference model: host queue plus clear bookkeeping
   host_wr_t mq[$];
   bit       m_clr;
   bit       m_pend;
   bit       m_err;
   int       m_age;

   bit                    e_wea, e_rst, e_cdone, e_drop;
   bit                    e_err, e_busy, e_ready;
   logic [BANK_WIDTH-1:0] e_bank;
   logic [ADDR_WIDTH-1:0] e_addr;
   logic [DATA_WIDTH-1:0] e_data;

   // memory stand-in
   int cyc = 0;
   bit auto_done = 1'b1;
   bit armed = 1'b0;
   int done_at = 0;
   int done_lat = 36;
   bit stray = 1'b0;
   bit rand_lat = 1'b0;

   int n_wea = 0, n_rst = 0, n_cdone = 0, n_drop = 0;
   int saw_nr = 0;
   int w0, r0, c0, d0;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h cyc=%0d",
                tag, obs, exp, cyc);
      end
   endtask

   task automatic model();
      host_wr_t h;
      bit acc;
      e_wea = 0; e_rst = 0; e_cdone = 0; e_drop = 0;
      if (reset) begin
         mq.delete();
         m_clr = 0; m_pend = 0; m_err = 0; m_age = 0;
         e_err = 0; e_busy = 0; e_ready = 0;
         return;
      end
      acc = host_valid && (mq.size() < FD);
      if (!m_clr) begin
         if (pipe_we) begin
            e_wea = 1; e_bank = pipe_bank;
            e_addr = pipe_addr; e_data = pipe_data;
         end else if (mq.size() > 0) begin
            h = mq.pop_front();
            e_wea = 1; e_bank = h.bank;
            e_addr = h.addr; e_data = h.data;
         end
         if (clear_req) begin
            m_clr = 1; m_age = 0;
         end
      end else begin
         e_drop = pipe_we;
         if (m_age == 0) begin
            e_rst = 1; m_age = 1;
            m_pend = m_pend | clear_req;
         end else if (mem_reset_done) begin
            e_cdone = 1;
            if (m_pend || clear_req) begin
               m_age = 0; m_pend = 0;
            end else begin
               m_clr = 0;
            end
         end else if (m_age == TMO) begin
            m_err = 1; m_clr = 0; m_pend = 0;
         end else begin
            m_age++;
            m_pend = m_pend | clear_req;
         end
      end
      if (acc) begin
         h.bank = host_bank; h.addr = host_addr;
         h.data = host_data;
         mq.push_back(h);
      end
      e_err   = m_err;
      e_busy  = m_clr || m_pend;
      e_ready = (mq.size() < FD);
   endtask

   task automatic step();
      mem_reset_done = stray || (armed && cyc == done_at);
      if (armed && cyc == done_at) armed = 0;
      model();
      @(posedge clk);
      #1;
      cyc++;
      chk("mem_wea", 32'(mem_wea), 32'(e_wea));
      if (e_wea) begin
         chk("mem_banka", 32'(mem_banka), 32'(e_bank));
         chk("mem_addra", 32'(mem_addra), 32'(e_addr));
         chk("mem_dia", 32'(mem_dia), 32'(e_data));
      end
      chk("mem_reset_mem", 32'(mem_reset_mem), 32'(e_rst));
      chk("clear_done", 32'(clear_done), 32'(e_cdone));
      chk("pipe_drop", 32'(pipe_drop), 32'(e_drop));
      chk("timeout_err", 32'(clear_timeout_err), 32'(e_err));
      chk("clear_busy", 32'(clear_busy), 32'(e_busy));
      chk("host_ready", 32'(host_ready), 32'(e_ready));
      if (mem_wea) n_wea++;
      if (mem_reset_mem) n_rst++;
      if (clear_done) n_cdone++;
      if (pipe_drop) n_drop++;
      if (!host_ready && !reset) saw_nr++;
      if (mem_reset_mem && auto_done) begin
         armed = 1;
         if (rand_lat) done_lat = $urandom_range(1, 40);
         done_at = cyc + done_lat;
      end
   endtask

   task automatic quiet();
      pipe_we = 0; host_valid = 0;
      clear_req = 0; stray = 0;
   endtask

   task automatic set_host(input int b, input int a, input int d);
      host_bank = BANK_WIDTH'(b);
      host_addr = ADDR_WIDTH'(a);
      host_data = DATA_WIDTH'(d);
   endtask

   task automatic rnd_pipe();
      pipe_bank = BANK_WIDTH'($urandom_range(0, NUM_BANKS-1));
      pipe_addr = ADDR_WIDTH'($urandom_range(0, DEPTH-1));
      pipe_data = DATA_WIDTH'($urandom);
   endtask

   task automatic rnd_host();
      set_host($urandom_range(0, NUM_BANKS-1),
               $urandom_range(0, DEPTH-1), $urandom);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      quiet();
      mem_reset_done = 0;
      rnd_pipe();
      set_host(0, 0, 0);
      reset = 1;
      run(2);
      reset = 0;
      run(2);

      // two host writes with pipe idle
      w0 = n_wea;
      host_valid = 1;
      set_host(0, 3, 8'hA5);
      step();
      set_host(1, 5, 8'h3C);
      step();
      host_valid = 0;
      run(4);
      chk("t1_write_count", 32'(n_wea - w0), 32'd2);
      chk("t1_never_notready", 32'(saw_nr), 32'd0);

      // pipe held 6 cycles while host fills the FIFO
      w0 = n_wea;
      pipe_we = 1;
      host_valid = 1;
      for (int i = 0; i < 6; i++) begin
         rnd_pipe();
         rnd_host();
         step();
      end
      quiet();
      run(8);
      chk("t2_write_count", 32'(n_wea - w0), 32'd10);
      chk("t2_full_seen", 32'(saw_nr > 0), 32'd1);

      // single clear with done 36 cycles after the pulse
      r0 = n_rst; c0 = n_cdone; w0 = n_wea;
      clear_req = 1;
      step();
      clear_req = 0;
      run(45);
      chk("t3_reset_pulses", 32'(n_rst - r0), 32'd1);
      chk("t3_done_pulses", 32'(n_cdone - c0), 32'd1);
      chk("t3_no_writes", 32'(n_wea - w0), 32'd0);

      // coalesced clear requests, pipe drops, queued host writes
      r0 = n_rst; c0 = n_cdone; d0 = n_drop; w0 = n_wea;
      clear_req = 1;
      step();
      clear_req = 0;
      run(5);
      clear_req = 1;
      step();
      clear_req = 0;
      run(3);
      clear_req = 1;
      step();
      clear_req = 0;
      pipe_we = 1;
      host_valid = 1;
      for (int i = 0; i < 3; i++) begin
         rnd_pipe();
         rnd_host();
         step();
      end
      quiet();
      run(100);
      chk("t4_reset_pulses", 32'(n_rst - r0), 32'd2);
      chk("t4_done_pulses", 32'(n_cdone - c0), 32'd2);
      chk("t4_drops", 32'(n_drop - d0), 32'd3);
      chk("t4_host_drained", 32'(n_wea - w0), 32'd3);

      // memory never answers: timeout
      auto_done = 0;
      c0 = n_cdone;
      clear_req = 1;
      step();
      clear_req = 0;
      run(TMO + 4);
      chk("t5_err_set", 32'(clear_timeout_err), 32'd1);
      chk("t5_idle", 32'(clear_busy), 32'd0);
      chk("t5_no_done", 32'(n_cdone - c0), 32'd0);
      w0 = n_wea;
      host_valid = 1;
      rnd_host();
      step();
      rnd_host();
      step();
      host_valid = 0;
      run(4);
      chk("t5_host_resumed", 32'(n_wea - w0), 32'd2);
      auto_done = 1;

      // reset in the middle of a wait with host writes queued
      reset = 1;
      step();
      reset = 0;
      step();
      clear_req = 1;
      step();
      clear_req = 0;
      run(3);
      host_valid = 1;
      rnd_host();
      step();
      rnd_host();
      step();
      host_valid = 0;
      run(2);
      reset = 1;
      step();
      reset = 0;
      w0 = n_wea; c0 = n_cdone;
      run(3);
      stray = 1;
      step();
      stray = 0;
      run(40);
      chk("t6_fifo_flushed", 32'(n_wea - w0), 32'd0);
      chk("t6_done_ignored", 32'(n_cdone - c0), 32'd0);

      // random traffic
      rand_lat = 1;
      for (int i = 0; i < 3000; i++) begin
         pipe_we = ($urandom_range(0, 99) < 40);
         host_valid = ($urandom_range(0, 99) < 50);
         clear_req = ($urandom_range(0, 99) < 2);
         stray = ($urandom_range(0, 199) == 0);
         rnd_pipe();
         rnd_host();
         step();
      end
      quiet();
      run(60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
